// File: rtl/i2c_target_port.sv
// I2C target endpoint: filtered SCL/SDA sampling, START/STOP detection, 7-bit address match,
// pointer-based register-file writes and auto-incrementing reads.
module i2c_target_port #(
  parameter logic [6:0]  TARGET_ADDR = 7'h42,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       addressed
);

  localparam logic [7:0] CntMax = 8'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    StIdle, StAddr, StRxPtr, StRxData, StAck, StTx, StRxAck, StIgnore
  } state_e;

  // Line vectors: bit 0 = SCL, bit 1 = SDA.
  logic [1:0] sync1_q, sync2_q, filt_q, filt_d, prev_q;
  logic [7:0] cnt_q [2];
  logic [7:0] cnt_d [2];

  state_e     state_q, state_d, ack_next_q, ack_next_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ack_on_q, ack_on_d;
  logic       oen_q, oen_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       busy_q, busy_d;
  logic       addressed_q, addressed_d;

  logic scl_f, sda_f, scl_p, sda_p;
  logic start_ev, stop_ev, sclr, sclf;
  logic [7:0] byte_in;

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = 8'd0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  assign scl_f    = filt_q[0];
  assign sda_f    = filt_q[1];
  assign scl_p    = prev_q[0];
  assign sda_p    = prev_q[1];
  assign start_ev = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_ev  = scl_f & scl_p & ~sda_p & sda_f;
  assign sclr     = scl_f & ~scl_p;
  assign sclf     = ~scl_f & scl_p;
  assign byte_in  = {shift_q[6:0], sda_f};

  always_comb begin
    state_d     = state_q;
    ack_next_d  = ack_next_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ack_on_d    = ack_on_q;
    oen_d       = oen_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    busy_d      = busy_q;
    addressed_d = addressed_q;

    // Pointer advances the cycle after a write strobe.
    if (we_q) addr_d = addr_q + 8'd1;

    if (start_ev) begin
      state_d     = StAddr;
      bit_cnt_d   = 4'd0;
      busy_d      = 1'b1;
      addressed_d = 1'b0;
      oen_d       = 1'b1;
    end else if (stop_ev) begin
      state_d     = StIdle;
      busy_d      = 1'b0;
      addressed_d = 1'b0;
      oen_d       = 1'b1;
    end else begin
      unique case (state_q)
        StAddr, StRxPtr, StRxData: begin
          if (sclr) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              ack_on_d  = 1'b0;
              state_d   = StAck;
              if (state_q == StAddr) begin
                if (byte_in[7:1] == TARGET_ADDR) begin
                  addressed_d = 1'b1;
                  ack_next_d  = byte_in[0] ? StTx : StRxPtr;
                end else begin
                  state_d = StIgnore;
                end
              end else if (state_q == StRxPtr) begin
                addr_d     = byte_in;
                ack_next_d = StRxData;
              end else begin
                wdata_d    = byte_in;
                we_d       = 1'b1;
                ack_next_d = StRxData;
              end
            end
          end
        end
        StAck: begin
          if (sclf) begin
            if (!ack_on_q) begin
              oen_d    = 1'b0;
              ack_on_d = 1'b1;
            end else begin
              ack_on_d = 1'b0;
              state_d  = ack_next_q;
              if (ack_next_q == StTx) begin
                // Read data bit 7 replaces the ACK drive directly.
                oen_d     = reg_rdata[7];
                shift_d   = {reg_rdata[6:0], 1'b0};
                bit_cnt_d = 4'd1;
              end else begin
                oen_d = 1'b1;
              end
            end
          end
        end
        StTx: begin
          if (sclf) begin
            if (bit_cnt_q == 4'd8) begin
              oen_d    = 1'b1;
              ack_on_d = 1'b0;
              state_d  = StRxAck;
            end else begin
              oen_d     = shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        StRxAck: begin
          if (sclr && !ack_on_q) begin
            if (!sda_f) begin
              ack_on_d = 1'b1;
              addr_d   = addr_q + 8'd1;
            end else begin
              state_d = StIgnore;
            end
          end else if (sclf && ack_on_q) begin
            ack_on_d  = 1'b0;
            state_d   = StTx;
            oen_d     = reg_rdata[7];
            shift_d   = {reg_rdata[6:0], 1'b0};
            bit_cnt_d = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      prev_q      <= 2'b11;
      cnt_q[0]    <= 8'd0;
      cnt_q[1]    <= 8'd0;
      state_q     <= StIdle;
      ack_next_q  <= StIdle;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      ack_on_q    <= 1'b0;
      oen_q       <= 1'b1;
      addr_q      <= 8'd0;
      wdata_q     <= 8'd0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
    end else begin
      sync1_q     <= {sda_i, scl_i};
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      prev_q      <= filt_q;
      cnt_q[0]    <= cnt_d[0];
      cnt_q[1]    <= cnt_d[1];
      state_q     <= state_d;
      ack_next_q  <= ack_next_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ack_on_q    <= ack_on_d;
      oen_q       <= oen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      addressed_q <= addressed_d;
    end
  end

  assign sda_o     = 1'b0;
  assign sda_oen   = oen_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign busy      = busy_q;
  assign addressed = addressed_q;

endmodule

// File: tb/tb_i2c_target_port.sv
// Bench for i2c_target_port: a bit-banged controller, a register file, and scoreboards for
// register writes and for every SDA bit the controller samples from the target.
module tb_i2c_target_port;
  localparam logic [6:0] TA = 7'h42;
  localparam int         HP = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       sda_line;
  logic       sda_o, sda_oen, reg_we, busy, addressed;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;

  logic [7:0] rf  [256];
  logic [7:0] mdl [256];
  logic [7:0] dbuf [8];
  logic [7:0] m_ptr;
  logic [15:0] exp_wr_q [$];
  logic        exp_bit_q [$];
  logic        rd_slot = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          oen_low_cnt = 0;
  int          busy_cnt = 0;

  i2c_target_port #(.TARGET_ADDR(TA), .FILTER_LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_drv),
    .sda_i     (sda_line),
    .sda_o     (sda_o),
    .sda_oen   (sda_oen),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .addressed (addressed)
  );

  always #5 clk = ~clk;

  // Wired-AND open-drain line.
  assign sda_line  = sda_drv & sda_oen;
  assign reg_rdata = rf[reg_addr];

  always @(posedge clk) if (reg_we) rf[reg_addr] <= reg_wdata;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!sda_oen) oen_low_cnt++;
    if (busy) busy_cnt++;
  end

  // Write scoreboard.
  always @(negedge clk) begin
    if (!rst && reg_we === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", reg_addr, reg_wdata);
      end else begin
        check("reg_write", {reg_addr, reg_wdata}, exp_wr_q.pop_front());
      end
    end
  end

  // SDA bit scoreboard: sampled mid-high in slots where the target owns the line.
  always @(posedge scl_drv) begin
    if (rd_slot) begin
      cyc(HP / 2);
      if (exp_bit_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_slot: got %0b, expected no slot", sda_line);
      end else begin
        check("sda_bit", {15'd0, sda_line}, {15'd0, exp_bit_q.pop_front()});
      end
    end
  end

  task automatic bus_start();
    if (!scl_drv) begin
      cyc(HP / 2); sda_drv = 1'b1; cyc(HP / 2); scl_drv = 1'b1; cyc(HP);
    end
    sda_drv = 1'b0; cyc(HP); scl_drv = 1'b0;
  endtask

  task automatic bus_stop();
    cyc(HP / 2); sda_drv = 1'b0; cyc(HP / 2); scl_drv = 1'b1; cyc(HP); sda_drv = 1'b1; cyc(HP);
  endtask

  task automatic clk_bit(input logic b, input logic slot);
    cyc(5); sda_drv = b; rd_slot = slot; cyc(HP - 5);
    scl_drv = 1'b1; cyc(HP); scl_drv = 1'b0; rd_slot = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack);
    for (int i = 7; i >= 0; i--) clk_bit(b[i], 1'b0);
    exp_bit_q.push_back(exp_ack);
    clk_bit(1'b1, 1'b1);
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic nack);
    for (int i = 7; i >= 0; i--) begin
      exp_bit_q.push_back(exp[i]);
      clk_bit(1'b1, 1'b1);
    end
    clk_bit(nack, 1'b0);
  endtask

  // Write transaction: address a, pointer, then n bytes from dbuf.
  task automatic do_write(input logic [6:0] a, input logic [7:0] ptr, input int n);
    logic hit;
    hit = (a == TA);
    bus_start();
    write_byte({a, 1'b0}, !hit);
    check("addressed_w", {15'd0, addressed}, {15'd0, hit});
    write_byte(ptr, !hit);
    if (hit) m_ptr = ptr;
    for (int k = 0; k < n; k++) begin
      if (hit) begin
        exp_wr_q.push_back({m_ptr, dbuf[k]});
        mdl[m_ptr] = dbuf[k];
        m_ptr = m_ptr + 8'd1;
      end
      write_byte(dbuf[k], !hit);
    end
    bus_stop();
    check("busy_after_stop", {15'd0, busy}, 16'd0);
    check("ptr_after_write", {8'd0, reg_addr}, {8'd0, m_ptr});
  endtask

  // Pointer write to TA, repeated START, read n bytes from address a.
  task automatic do_read(input logic [6:0] a, input logic [7:0] ptr, input int n);
    logic hit;
    hit = (a == TA);
    bus_start();
    write_byte({TA, 1'b0}, 1'b0);
    write_byte(ptr, 1'b0);
    m_ptr = ptr;
    bus_start();
    write_byte({a, 1'b1}, !hit);
    check("addressed_r", {15'd0, addressed}, {15'd0, hit});
    if (hit) begin
      for (int k = 0; k < n; k++) begin
        read_byte(mdl[m_ptr], k == n - 1);
        if (k != n - 1) m_ptr = m_ptr + 8'd1;
      end
    end
    bus_stop();
    check("busy_after_read", {15'd0, busy}, 16'd0);
    check("ptr_after_read", {8'd0, reg_addr}, {8'd0, m_ptr});
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    logic [6:0] ra;
    for (int i = 0; i < 256; i++) begin
      mdl[i] = 8'($urandom);
      rf[i]  = mdl[i];
    end
    m_ptr = 8'd0;
    cyc(5);
    rst = 1'b0;
    cyc(1);
    check("rst_oen", {15'd0, sda_oen}, 16'd1);
    check("rst_sda_o", {15'd0, sda_o}, 16'd0);
    check("rst_we", {15'd0, reg_we}, 16'd0);
    check("rst_addr_wdata", {reg_addr, reg_wdata}, 16'd0);
    check("rst_busy_addr", {14'd0, busy, addressed}, 16'd0);
    cyc(10);

    // Basic write.
    dbuf[0] = 8'hA5; dbuf[1] = 8'h3C;
    do_write(TA, 8'h05, 2);
    check("write_final_ptr", {8'd0, reg_addr}, 16'h0007);

    // Read through repeated START.
    mdl[8'h10] = 8'h5A; rf[8'h10] = 8'h5A;
    mdl[8'h11] = 8'hC3; rf[8'h11] = 8'hC3;
    do_read(TA, 8'h10, 2);
    check("read_final_ptr", {8'd0, reg_addr}, 16'h0011);

    // Address mismatch: SDA never pulled low.
    snap = oen_low_cnt;
    do_write(7'h43, 8'h01, 0);
    check("mismatch_oen_low_cycles", 16'(oen_low_cnt - snap), 16'd0);

    // Glitch filtering on SDA in idle.
    snap = busy_cnt;
    sda_drv = 1'b0; cyc(3); sda_drv = 1'b1; cyc(20);
    check("glitch3_busy_cycles", 16'(busy_cnt - snap), 16'd0);
    snap = busy_cnt;
    sda_drv = 1'b0; cyc(5); sda_drv = 1'b1; cyc(20);
    check("glitch5_busy_seen", {15'd0, (busy_cnt - snap) > 0}, 16'd1);
    check("glitch5_busy_end", {15'd0, busy}, 16'd0);

    // Pointer wrap.
    dbuf[0] = 8'h11; dbuf[1] = 8'h22;
    do_write(TA, 8'hFF, 2);
    check("wrap_ptr", {8'd0, reg_addr}, 16'h0001);

    // STOP in the middle of a data byte.
    bus_start();
    write_byte({TA, 1'b0}, 1'b0);
    write_byte(8'h30, 1'b0);
    m_ptr = 8'h30;
    for (int i = 0; i < 4; i++) clk_bit(1'b0, 1'b0);
    bus_stop();
    check("midstop_busy", {15'd0, busy}, 16'd0);
    check("midstop_ptr", {8'd0, reg_addr}, 16'h0030);

    // Reset while the target drives read bit 3 low.
    mdl[8'h20] = 8'hF0; rf[8'h20] = 8'hF0;
    bus_start();
    write_byte({TA, 1'b0}, 1'b0);
    write_byte(8'h20, 1'b0);
    bus_start();
    write_byte({TA, 1'b1}, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_bit_q.push_back(1'b1);
      clk_bit(1'b1, 1'b1);
    end
    cyc(HP / 2);
    check("tx_bit3_low", {15'd0, sda_oen}, 16'd0);
    rst = 1'b1;
    cyc(1);
    check("rst_mid_oen", {15'd0, sda_oen}, 16'd1);
    check("rst_mid_busy_addr", {14'd0, busy, addressed}, 16'd0);
    check("rst_mid_ptr", {8'd0, reg_addr}, 16'd0);
    rst = 1'b0;
    m_ptr = 8'd0;
    sda_drv = 1'b1; cyc(5); scl_drv = 1'b1; cyc(HP);

    // Randomized transactions against the model.
    for (int t = 0; t < 12; t++) begin
      ra = ($urandom_range(0, 2) != 0) ? TA : 7'($urandom);
      if (ra == TA && ($urandom_range(0, 3) == 0)) ra = TA ^ 7'h01;
      if ($urandom_range(0, 1) == 1) begin
        int n;
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) dbuf[k] = 8'($urandom);
        do_write(ra, 8'($urandom), n);
      end else begin
        do_read(ra, 8'($urandom), $urandom_range(1, 3));
      end
    end

    cyc(10);
    check("write_queue_drained", 16'(exp_wr_q.size()), 16'd0);
    check("bit_queue_drained", 16'(exp_bit_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
